// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller: dual/single/rotate
// channel views, frame-aligned mode latching and leading-zero blanking.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS    = 8,
    parameter int NUM_CH        = 4,
    parameter int REFRESH_DIV   = 100000,
    parameter int ROTATE_FRAMES = 500,
    localparam int HALF  = NUM_DIGITS / 2,
    localparam int CH_W  = 4 * HALF,
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*CH_W-1:0]   digits,
    input  logic [1:0]               sw_mode,
    input  logic [SEL_W-1:0]         ch_sel,
    input  logic                     lz_blank,
    output logic [6:0]               segments,
    output logic [NUM_DIGITS-1:0]    anodes,
    output logic                     frame_start
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int ROT_W = (ROTATE_FRAMES > 1) ? $clog2(ROTATE_FRAMES) : 1;

    localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(HALF);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
    localparam logic [ROT_W-1:0] LAST_ROT = ROT_W'(ROTATE_FRAMES - 1);

    typedef enum logic [1:0] {
        MODE_DUAL   = 2'd0,
        MODE_SINGLE = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_BLANK  = 2'd3
    } mode_e;

    logic [PRE_W-1:0]      prescaler_r;
    logic [IDX_W-1:0]      digit_idx_r;
    mode_e                 act_mode_r;
    logic [SEL_W-1:0]      act_sel_r;
    logic [SEL_W-1:0]      rot_ch_r;
    logic [ROT_W-1:0]      rot_cnt_r;
    logic [NUM_DIGITS-1:0] anodes_r;
    logic [6:0]            segments_r;
    logic                  frame_start_r;

    logic                  tick_s;
    logic                  wrap_s;
    logic                  upper_s;
    logic [IDX_W-1:0]      nib_idx_s;
    logic [SEL_W-1:0]      next_sel_s;
    logic [SEL_W-1:0]      ch_s;
    logic                  show_s;
    logic [CH_W-1:0]       ch_data_s;
    logic [3:0]            nibble_s;
    logic                  lz_hide_s;
    logic [NUM_DIGITS-1:0] anodes_nxt_s;
    logic [6:0]            segments_nxt_s;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    assign tick_s     = (prescaler_r == LAST_PRE);
    assign wrap_s     = tick_s && (digit_idx_r == LAST_IDX);
    assign next_sel_s = (act_sel_r == LAST_CH) ? {SEL_W{1'b0}} : act_sel_r + {{(SEL_W-1){1'b0}}, 1'b1};

    // Pick which channel and nibble the current digit slot shows.
    always_comb begin
        show_s    = 1'b0;
        ch_s      = {SEL_W{1'b0}};
        ch_data_s = {CH_W{1'b0}};
        upper_s   = (digit_idx_r >= HALF_IDX);
        nib_idx_s = upper_s ? (digit_idx_r - HALF_IDX) : digit_idx_r;
        case (act_mode_r)
            MODE_DUAL: begin
                show_s = 1'b1;
                ch_s   = upper_s ? next_sel_s : act_sel_r;
            end
            MODE_SINGLE: begin
                show_s = !upper_s;
                ch_s   = act_sel_r;
            end
            MODE_ROTATE: begin
                show_s = !upper_s;
                ch_s   = rot_ch_r;
            end
            default: begin
                show_s = 1'b0;
                ch_s   = {SEL_W{1'b0}};
            end
        endcase
        // A select beyond the last channel (non-power-of-two NUM_CH) shows nothing.
        if (int'(ch_s) < NUM_CH) begin
            ch_data_s = digits[int'(ch_s)*CH_W +: CH_W];
        end else begin
            show_s    = 1'b0;
            ch_data_s = {CH_W{1'b0}};
        end
        nibble_s  = ch_data_s[int'(nib_idx_s)*4 +: 4];
        lz_hide_s = lz_blank && (nib_idx_s != {IDX_W{1'b0}}) &&
                    ((ch_data_s >> {nib_idx_s, 2'b00}) == {CH_W{1'b0}});
    end

    // Next anode/segment drive; the tick cycle is forced dark to avoid ghosting.
    always_comb begin
        anodes_nxt_s   = {NUM_DIGITS{1'b1}};
        segments_nxt_s = 7'h7F;
        if (tick_s) begin
            anodes_nxt_s   = {NUM_DIGITS{1'b1}};
            segments_nxt_s = 7'h7F;
        end else if (show_s && !lz_hide_s) begin
            anodes_nxt_s[digit_idx_r] = 1'b0;
            segments_nxt_s            = hex_to_seg(nibble_s);
        end else begin
            anodes_nxt_s   = {NUM_DIGITS{1'b1}};
            segments_nxt_s = 7'h7F;
        end
    end

    // Prescaler, digit index and frame-aligned mode latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_r   <= {PRE_W{1'b0}};
            digit_idx_r   <= {IDX_W{1'b0}};
            act_mode_r    <= MODE_BLANK;
            act_sel_r     <= {SEL_W{1'b0}};
            frame_start_r <= 1'b0;
        end else begin
            prescaler_r   <= tick_s ? {PRE_W{1'b0}} : prescaler_r + {{(PRE_W-1){1'b0}}, 1'b1};
            frame_start_r <= wrap_s;
            if (tick_s) begin
                digit_idx_r <= (digit_idx_r == LAST_IDX) ? {IDX_W{1'b0}}
                                                         : digit_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
            if (wrap_s) begin
                act_mode_r <= mode_e'(sw_mode);
                act_sel_r  <= ch_sel;
            end
        end
    end

    // Rotate-mode channel stepping; restarts at channel 0 when rotate is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_ch_r  <= {SEL_W{1'b0}};
            rot_cnt_r <= {ROT_W{1'b0}};
        end else if (wrap_s) begin
            if ((mode_e'(sw_mode) == MODE_ROTATE) && (act_mode_r != MODE_ROTATE)) begin
                rot_ch_r  <= {SEL_W{1'b0}};
                rot_cnt_r <= {ROT_W{1'b0}};
            end else if (rot_cnt_r == LAST_ROT) begin
                rot_cnt_r <= {ROT_W{1'b0}};
                rot_ch_r  <= (rot_ch_r == LAST_CH) ? {SEL_W{1'b0}}
                                                   : rot_ch_r + {{(SEL_W-1){1'b0}}, 1'b1};
            end else begin
                rot_cnt_r <= rot_cnt_r + {{(ROT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anodes_r   <= {NUM_DIGITS{1'b1}};
            segments_r <= 7'h7F;
        end else begin
            anodes_r   <= anodes_nxt_s;
            segments_r <= segments_nxt_s;
        end
    end

    assign anodes      = anodes_r;
    assign segments    = segments_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: expected slot images are queued per
// frame when inputs are driven and popped as each digit slot is displayed.
module tb_seven_seg_scan_ctrl;

    localparam int ND    = 8;
    localparam int NC    = 4;
    localparam int RD    = 4;
    localparam int RF    = 2;
    localparam int CW    = 16;
    localparam int FRAME = ND * RD;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NC*CW-1:0] digits;
    logic [1:0]     sw_mode;
    logic [1:0]     ch_sel;
    logic           lz_blank;
    logic [6:0]     segments;
    logic [ND-1:0]  anodes;
    logic           frame_start;

    int n_tests = 0;
    int n_fail  = 0;
    int kcnt    = 0;
    bit mon_en  = 1'b0;

    logic [14:0] sb_q[$];
    logic [14:0] cur_exp;
    int m_prev = 3;
    int rc     = 0;
    int rcnt   = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    localparam logic [63:0] D_A = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
    localparam logic [63:0] D_R = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(ND), .NUM_CH(NC), .REFRESH_DIV(RD), .ROTATE_FRAMES(RF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .sw_mode(sw_mode), .ch_sel(ch_sel),
        .lz_blank(lz_blank), .segments(segments), .anodes(anodes), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Posedges since reset release; the bench's own notion of scan timing.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) kcnt <= 0;
        else        kcnt <= kcnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] exp_slot(input int d, input int mode, input int sel,
                                             input bit lz, input int rch, input logic [63:0] dv);
        int ch;
        bit show;
        int n;
        logic [15:0] v;
        logic [3:0]  nib;
        n = d % (ND/2);
        ch = 0;
        show = 1'b0;
        case (mode)
            0:       begin show = 1'b1; ch = (d >= ND/2) ? (sel + 1) % NC : sel; end
            1:       begin show = (d < ND/2); ch = sel; end
            2:       begin show = (d < ND/2); ch = rch; end
            default: show = 1'b0;
        endcase
        if (!show) return {8'hFF, 7'h7F};
        v   = dv[ch*CW +: CW];
        nib = v[4*n +: 4];
        if (lz && n > 0 && (v >> (4*n)) == 16'h0000) return {8'hFF, 7'h7F};
        return {~(8'd1 << d), seg_tab[nib]};
    endfunction

    task automatic wait_k(input int t);
        int guard = 0;
        while (kcnt != t && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (kcnt != t) check_val("wait_k timeout", kcnt, t);
    endtask

    // Drive the inputs that latch at the wrap into frame f and queue that frame's slots.
    task automatic drive_frame(input int f, input int mode, input int sel, input bit lz,
                               input logic [63:0] dv, input int mid_mode);
        wait_k(f*FRAME - 1);
        sw_mode  = mode[1:0];
        ch_sel   = sel[1:0];
        lz_blank = lz;
        digits   = dv;
        if (mode == 2 && m_prev != 2) begin
            rc = 0; rcnt = 0;
        end else if (rcnt == RF - 1) begin
            rcnt = 0; rc = (rc + 1) % NC;
        end else begin
            rcnt++;
        end
        m_prev = mode;
        for (int d = 0; d < ND; d++) sb_q.push_back(exp_slot(d, mode, sel, lz, rc, dv));
        if (mid_mode >= 0) begin
            wait_k(f*FRAME + 13);
            sw_mode = mid_mode[1:0];
        end
    endtask

    // Compare every display cycle against the scoreboard and the frame marker.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check_val("frame_start", {31'd0, frame_start}, {31'd0, (kcnt > 0 && kcnt % FRAME == 0)});
            if (kcnt % RD == 0) begin
                check_val("ghost_off", {24'd0, anodes}, 32'h0000_00FF);
            end else begin
                if (kcnt % RD == 1) begin
                    if (sb_q.size() == 0) begin
                        check_val("sb_empty", sb_q.size(), 32'd1);
                        cur_exp = {8'hFF, 7'h7F};
                    end else begin
                        cur_exp = sb_q.pop_front();
                    end
                end
                check_val($sformatf("slot k=%0d", kcnt), {17'd0, anodes, segments}, {17'd0, cur_exp});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        digits = '0; sw_mode = 2'd0; ch_sel = 2'd0; lz_blank = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_anodes", {24'd0, anodes}, 32'h0000_00FF);
        check_val("rst_segments", {25'd0, segments}, 32'h0000_007F);
        check_val("rst_frame_start", {31'd0, frame_start}, 32'd0);
        for (int d = 0; d < ND; d++) sb_q.push_back({8'hFF, 7'h7F});
        rst_n  = 1'b1;
        mon_en = 1'b1;

        drive_frame(1, 0, 0, 0, D_A, -1);
        drive_frame(2, 0, 0, 0, D_A, 1);
        drive_frame(3, 1, 0, 0, D_A, -1);
        drive_frame(4, 0, 3, 0, D_A, -1);
        drive_frame(5, 1, 0, 1, {16'hDEF0, 16'h9ABC, 16'h5678, 16'h0040}, -1);
        drive_frame(6, 1, 0, 1, {16'hDEF0, 16'h9ABC, 16'h5678, 16'h0000}, -1);
        drive_frame(7, 0, 0, 1, {16'hDEF0, 16'h9ABC, 16'h0007, 16'h0100}, -1);
        for (int f = 8; f < 18; f++) drive_frame(f, 2, 1, 0, D_R, -1);
        drive_frame(18, 3, 0, 0, D_A, -1);
        drive_frame(19, 1, 2, 0, D_A, -1);

        wait_k(19*FRAME + 6);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_anodes", {24'd0, anodes}, 32'h0000_00FF);
        check_val("midrst_segments", {25'd0, segments}, 32'h0000_007F);
        check_val("midrst_frame_start", {31'd0, frame_start}, 32'd0);
        sb_q.delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
